disp_ram_rd_streamer: RTL
=========================

DISP_RAM_RD_STREAMER -- requirements
Module: disp_ram_rd_streamer

Interface
REQ-001 SHALL have parameter DATA_W, 32, RAM word width.
REQ-002 SHALL have parameter ADDR_W, 10, RAM address width (1024 words).
REQ-003 SHALL have parameter RD_LATENCY, 2, RAM read latency in cycles from the ram_en cycle to the ram_dout-valid cycle.
REQ-004 SHALL have parameter FIFO_DEPTH, 4, output buffer depth in words; minimum RD_LATENCY+2.
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port cmd_valid, input, 1, read command valid.
REQ-008 SHALL have port cmd_ready, output, 1, command accept.
REQ-009 SHALL have port cmd_addr, input, ADDR_W, start word address.
REQ-010 SHALL have port cmd_len, input, ADDR_W+1, word count, 0..1024.
REQ-011 SHALL have ports ram_en (output, 1), ram_we (output, 4), ram_addr (output, ADDR_W) and ram_dout (input, DATA_W), the RAM read-port connection.
REQ-012 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, DATA_W) and m_last (output, 1), the output word stream.
REQ-013 SHALL have ports busy (output, 1), high when not IDLE, and done (output, 1), a one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DRAIN; cmd_ready = (state==IDLE).
REQ-015 SHALL, on cmd_valid&&cmd_ready, latch the address and set remaining=cmd_len; go to RUN if len!=0, else stay IDLE and pulse done the next cycle.
REQ-016 SHALL, in RUN, issue a read (ram_en=1, ram_addr=current address) in a cycle iff remaining!=0 and inflight+fifo_count<FIFO_DEPTH.
REQ-017 SHALL, per issued read, decrement remaining and increment the address modulo 2^ADDR_W (1023 wraps to 0).
REQ-018 SHALL drive ram_we to 4'b0000 at all times and hold ram_en at 0 when no read is issued.
REQ-019 SHALL track issues in a RD_LATENCY-deep valid/last shift pipeline and sample ram_dout into the FIFO in cycle n+RD_LATENCY for a read issued in cycle n, giving m_valid in cycle n+RD_LATENCY+1.
REQ-020 SHALL tag the read issued with remaining==1 as last; m_last SHALL be high only with that word at the FIFO head.
REQ-021 SHALL drive m_valid = FIFO non-empty and m_data = FIFO head; a word is removed only on m_valid&&m_ready.
REQ-022 SHALL hold m_data/m_last stable while m_valid&&!m_ready.
REQ-023 SHALL leave occupancy unchanged on a simultaneous push and pop; the credit rule SHALL make a push into a full FIFO impossible.
REQ-024 SHALL sustain 1 word/cycle with m_ready held high.
REQ-025 SHALL go from RUN to DRAIN when remaining reaches 0.
REQ-026 SHALL go from DRAIN to IDLE on the m_last handshake, with done=1 and cmd_ready=1 in the following cycle.
REQ-027 SHALL ignore cmd_valid while busy; no command is queued.

Reset
REQ-028 SHALL, while rst is high, immediately force: state IDLE, FIFO and pipeline empty, counters 0, and ram_en, m_valid, m_last, busy, done and cmd_ready all 0.
REQ-029 SHALL, in the first cycle after rst deasserts, have cmd_ready=1 and all other outputs 0.
REQ-030 SHALL, on reset mid-transfer, discard in-flight reads, output no further words, emit no done, and never push RAM data returning after reset into the FIFO.

Verification
REQ-031 SHALL cover: RAM word k = k; cmd addr=5, len=4, m_ready=1 -> ram_en in 4 consecutive cycles at addr 5..8; m_data 5,6,7,8 back-to-back, first m_valid 3 cycles after first ram_en; m_last only on 8; done 1 cycle after it.
REQ-032 SHALL cover: addr=1022, len=4 -> ram_addr 1022,1023,0,1; m_data 1022,1023,0,1.
REQ-033 SHALL cover: len=16 with m_ready low for 10 cycles -> at most 4 outstanding (issued but unconsumed); then all 16 words in order with none lost or duplicated.
REQ-034 SHALL cover: len=0 -> no ram_en, no m_valid, done 1 cycle after accept, cmd_ready stays 1.
REQ-035 SHALL cover: rst pulsed after 3 of 8 words -> outputs 0 immediately; a new cmd addr=0, len=2 streams exactly words 0,1.
REQ-036 SHALL cover: random m_ready over 1024-word transfer -> data matches, m_last once, no FIFO overflow.

Source files
------------

// File: rtl/disp_ram_rd_streamer_if.sv
// Bundle of the command, RAM read-port, output-stream and status signals
// of the display RAM read streamer.
// The slave modport is the streamer's view. The master modport is the
// view of the surrounding logic, which issues commands, returns RAM data
// and consumes the output stream.
interface disp_ram_rd_streamer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W:0]   cmd_len;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_dout;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              busy;
   logic              done;

   modport master (
      output cmd_valid, cmd_addr, cmd_len, ram_dout, m_ready,
      input  cmd_ready, ram_en, ram_we, ram_addr, m_valid, m_data, m_last, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, ram_dout, m_ready,
      output cmd_ready, ram_en, ram_we, ram_addr, m_valid, m_data, m_last, busy, done
   );
endinterface

// File: rtl/disp_ram_rd_streamer.sv
// Display RAM read streamer.
// It accepts one (address, length) command and reads consecutive RAM words,
// wrapping the address. It streams the words out through a small FIFO.
// Reads are only issued when the FIFO is guaranteed room for them: the
// words still in flight plus the words already buffered must stay below
// the FIFO depth. Because of this credit rule the FIFO never overflows.
// The bus interface widths must match DATA_W/ADDR_W.
module disp_ram_rd_streamer #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 10,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input logic                   clk,
   input logic                   rst,
   disp_ram_rd_streamer_if.slave bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W:0]    DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   LEN_ZERO = '0;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W:0]   remaining_reg;
   logic              done_reg;
   logic              vld_pipe  [RD_LATENCY];
   logic              last_pipe [RD_LATENCY];
   logic [DATA_W-1:0] data_mem  [FIFO_DEPTH];
   logic              last_mem  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  inflight;
   logic              accept, issue, issue_last, push, pop, fifo_valid, last_hs;

   assign accept     = bus.cmd_valid && bus.cmd_ready;
   assign push       = vld_pipe[RD_LATENCY-1];
   assign fifo_valid = (count_reg != '0);
   assign pop        = fifo_valid && bus.m_ready;
   assign last_hs    = pop && last_mem[rd_ptr_reg];
   assign issue_last = issue && (remaining_reg == LEN_ONE);

   // Number of reads issued whose data has not yet reached the FIFO
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CNT_W'(vld_pipe[i]);
      end
   end

   // Next-state and read-issue decision
   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept && (bus.cmd_len != LEN_ZERO)) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if ((remaining_reg != LEN_ZERO) &&
                (({1'b0, inflight} + {1'b0, count_reg}) < DEPTH_L)) begin
               issue = 1'b1;
               if (remaining_reg == LEN_ONE) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (last_hs) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Address/length counters and the completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg      <= '0;
         remaining_reg <= '0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= (accept && (bus.cmd_len == LEN_ZERO)) || ((state_reg == DRAIN) && last_hs);
         if (accept) begin
            addr_reg      <= bus.cmd_addr;
            remaining_reg <= bus.cmd_len;
         end else if (issue) begin
            addr_reg      <= addr_reg + 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
         end
      end
   end

   // Shift pipeline that follows each read until its data appears on ram_dout
   for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
         // The first stage captures the read being issued this cycle
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_pipe[gi]  <= 1'b0;
               last_pipe[gi] <= 1'b0;
            end else begin
               vld_pipe[gi]  <= issue;
               last_pipe[gi] <= issue_last;
            end
         end
      end else begin : g_tail
         // Later stages shift the tag along, one stage per cycle
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_pipe[gi]  <= 1'b0;
               last_pipe[gi] <= 1'b0;
            end else begin
               vld_pipe[gi]  <= vld_pipe[gi-1];
               last_pipe[gi] <= last_pipe[gi-1];
            end
         end
      end
   end

   // FIFO storage: capture returning RAM data with its last tag
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_reg] <= bus.ram_dout;
         last_mem[wr_ptr_reg] <= last_pipe[RD_LATENCY-1];
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop keeps the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_MAX) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_MAX) ? '0 : rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // cmd_ready is gated by rst so that it reads 0 while reset is held
   assign bus.cmd_ready = (state_reg == IDLE) && !rst;
   assign bus.busy      = (state_reg != IDLE);
   assign bus.done      = done_reg;
   assign bus.ram_en    = issue;
   assign bus.ram_we    = 4'b0000;
   assign bus.ram_addr  = addr_reg;
   assign bus.m_valid   = fifo_valid;
   assign bus.m_data    = data_mem[rd_ptr_reg];
   assign bus.m_last    = fifo_valid && last_mem[rd_ptr_reg];
endmodule
